// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - RV32I load/store data-memory controller with byte-lane strobes
// Optional WAIT-state timeout enabled by defining DMEM_TIMEOUT_EN (limit TIMEOUT_CYC).
module dmem_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_ld_data,
  output logic        rsp_misalign,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]  state;
  logic [1:0]  byte_off;
  logic        f3_legal;
  logic        misal;
  logic [3:0]  strb_d;
  logic [31:0] wdata_d;

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYC + 1) < 8) ? 8 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] wait_cnt;
`endif

  assign req_ready = (state == S_IDLE);
  assign stall     = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign mem_req   = (state == S_REQ);

  // Width decode: func3[1:0] gives size, func3[2] marks unsigned loads only
  always_comb begin
    misal   = 1'b0;
    strb_d  = 4'b0000;
    wdata_d = req_wdata;
    case (req_func3[1:0])
      2'b00: begin
        strb_d  = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        strb_d  = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
        misal   = req_addr[0];
      end
      2'b10: begin
        strb_d = 4'b1111;
        misal  = |req_addr[1:0];
      end
      default: ;
    endcase
    if (req_we) begin
      f3_legal = !req_func3[2] && (req_func3[1:0] != 2'b11);
    end else begin
      f3_legal = (req_func3[1:0] != 2'b11) && !(req_func3[2] && req_func3[1]);
      strb_d   = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      byte_off     <= 2'b00;
      rsp_ld_data  <= 32'h0;
      rsp_misalign <= 1'b0;
      rsp_err      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_wstrb    <= 4'b0000;
      mem_wdata    <= 32'h0;
`ifdef DMEM_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            mem_we    <= req_we;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wstrb <= strb_d;
            mem_wdata <= wdata_d;
            byte_off  <= req_addr[1:0];
            if (!f3_legal) begin
              rsp_err <= 1'b1;
              state   <= S_RESP;
            end else if (misal) begin
              rsp_misalign <= 1'b1;
              state        <= S_RESP;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            state <= mem_we ? S_RESP : S_WAIT;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            rsp_ld_data <= mem_rdata >> {byte_off, 3'b000};
            state       <= S_RESP;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            rsp_err <= 1'b1;
            state   <= S_RESP;
          end
          wait_cnt <= wait_cnt + 1'b1;
`endif
        end
        S_RESP: begin
          state        <= S_IDLE;
          rsp_ld_data  <= 32'h0;
          rsp_misalign <= 1'b0;
          rsp_err      <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller for the RV32I core's load/store path. Takes one load or store request at a time from the execute stage, drives a handshaked data-memory port with byte-lane strobes, and returns the right-aligned raw load word. That word feeds the downstream load sign/zero-extension filter. The controller asserts `stall` while a transaction is outstanding.

## Interface
- `TIMEOUT_CYC`, 255: WAIT-state cycle limit; used only with `DMEM_TIMEOUT_EN`.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `req_valid` in 1: load/store request present.
- `req_ready` out 1: high only in IDLE. The request is accepted when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_func3` in 3: width code; loads 000/001/010/100/101, stores 000/001/010.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `stall` out 1: high in every state except IDLE.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_ld_data` out 32: load word shifted right by 8·addr[1:0], zero-filled; 0 for stores and errors.
- `rsp_misalign` out 1: valid with `rsp_valid`.
- `rsp_err` out 1: valid with `rsp_valid`; flags illegal func3 or timeout.
- `mem_req` out 1: memory request, held until granted.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: word-aligned address ({addr[31:2],2'b00}).
- `mem_wstrb` out 4: byte-lane strobes; 0 for loads.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_gnt` in 1: memory accepted the request.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read data.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE on accept:
  - Latch we, func3, addr[1:0], mem_addr, mem_wstrb, mem_wdata.
  - Illegal func3 (loads 011/110/111; stores anything other than 000/001/010): go to RESP with `rsp_err`=1 and no memory access.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0): go to RESP with `rsp_misalign`=1 and no memory access.
  - Otherwise go to REQ.
- Store lanes:
  - sb: wstrb = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - sh: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - sw: wstrb = 4'b1111, wdata unchanged.
- REQ: `mem_req`=1 with stable address, strobes and data. On `mem_gnt`, a store goes to RESP and a load goes to WAIT. Without `mem_gnt`, stay in REQ indefinitely.
- WAIT: `mem_rvalid` is sampled only here. On `mem_rvalid`, register `mem_rdata`>>(8·addr[1:0]) into `rsp_ld_data` and go to RESP.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE. Response outputs are cleared to 0 on entry to IDLE.
- `mem_rvalid`/`mem_gnt` outside their sampling states are ignored.

## Timing
- Reset values: state IDLE, `req_ready`=1, `stall`=0, `rsp_valid`=0, `rsp_misalign`=0, `rsp_err`=0, `rsp_ld_data`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wstrb`=0, `mem_wdata`=0.
- All outputs are registered or decoded from state only. There is no combinational path from `req_*` or `mem_*` inputs to any output.
- Accept at cycle N:
  - `mem_req` is high from N+1.
  - With gnt at N+1, a store's `rsp_valid` is at N+2.
  - A load's `rsp_valid` is one cycle after the `mem_rvalid` cycle; minimum N+3.
- Error/misalign: `rsp_valid` at N+1.
- Back-to-back: next accept is possible the cycle after RESP (IDLE), giving 1 idle cycle between transactions.
- `rst` mid-transaction: IDLE on the next edge, `mem_req` drops, and any later `mem_rvalid` is ignored.

## Configuration
- `DMEM_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYC` without `mem_rvalid`, go to RESP with `rsp_err`=1 and `rsp_ld_data`=0.
  - If `mem_rvalid` arrives in the same cycle as the limit, the data wins.
- Not defined: no counter; WAIT lasts until `mem_rvalid`, and `rsp_err` reports illegal func3 only.

## Test plan
- lw addr 0x100, gnt at N+1, rvalid at N+3 with rdata 0xDEADBEEF -> `rsp_valid` at N+4, `rsp_ld_data`=0xDEADBEEF, flags 0.
- lb addr 0x103, rdata 0x80112233 -> `rsp_ld_data`=0x00000080; lh addr 0x102 -> 0x00008011.
- sb addr 0x201 wdata 0x000000A5 -> `mem_addr`=0x200, `mem_wstrb`=0010, `mem_wdata`=0xA5A5A5A5; sh 0x202 -> wstrb 1100.
- lw addr 0x102 -> `rsp_valid` at N+1 with `rsp_misalign`=1 and `mem_req` never high; load func3 011 -> `rsp_err`=1.
- gnt withheld 5 cycles -> `mem_req` and `stall` held and outputs stable; `rst` during WAIT followed by `mem_rvalid` -> no `rsp_valid`, `req_ready`=1.
- With `DMEM_TIMEOUT_EN` and `TIMEOUT_CYC`=4, rvalid never arrives -> `rsp_valid` with `rsp_err`=1 exactly 4 cycles after WAIT entry.
